// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter in front of a shared binary-to-Gray converter.
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] bin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] bin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] gray_out,
    output logic             busy,
    output logic [7:0]       conv_cnt
);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d, gray_q, gray_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             own_q, own_d, last_q, last_d, win;
    always_comb begin
        win     = (req0 && req1) ? ~last_q : req1;
        state_d = state_q;
        op_d    = op_q;
        gray_d  = gray_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (req0 || req1) begin
                state_d = CONVERT;
                own_d   = win;
                op_d    = win ? bin1 : bin0;
            end
            CONVERT: begin
                state_d = DONE;
                gray_d  = op_q ^ (op_q >> 1);
            end
            DONE: begin
                state_d = IDLE;
                last_d  = own_q;
                cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    // last_q resets to 1 so requester 0 wins the first contended arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
            last_q  <= last_d;
        end
    end
    assign gnt0     = (state_q == CONVERT) && !own_q;
    assign gnt1     = (state_q == CONVERT) && own_q;
    assign done0    = (state_q == DONE) && !own_q;
    assign done1    = (state_q == DONE) && own_q;
    assign busy     = (state_q != IDLE);
    assign gray_out = gray_q;
    assign conv_cnt = cnt_q;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed checks of grant/done timing, Gray results, arbitration and counter.
module tb_gray_conv_arbiter;
    logic       clk = 1'b0;
    logic       rst, req0, req1, gnt0, gnt1, done0, done1, busy;
    logic [3:0] bin0, bin1, gray_out;
    logic [7:0] conv_cnt;
    logic [7:0] exp_cnt;
    int         vectors = 0;
    int         miscompares = 0;

    gray_conv_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .gray_out(gray_out), .busy(busy), .conv_cnt(conv_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // single-requester conversion: gnt, done one cycle later, then back to IDLE
    task automatic conv(input logic who, input logic [3:0] b, input logic [3:0] expg);
        if (who) begin req1 = 1'b1; bin1 = b; end
        else begin req0 = 1'b1; bin0 = b; end
        step();
        chk("gnt0", gnt0, !who);
        chk("gnt1", gnt1, who);
        chk("busy_conv", busy, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        chk("done0", done0, !who);
        chk("done1", done1, who);
        chk("gray", gray_out, expg);
        step();
        exp_cnt = exp_cnt + 8'd1;
        chk("busy_idle", busy, 0);
        chk("cnt", conv_cnt, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0; exp_cnt = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_gray", gray_out, 0);
        chk("rst_cnt", conv_cnt, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1}, 0);

        for (int i = 0; i < 16; i++) begin
            logic [3:0] b;
            b = 4'(i);
            conv(1'b0, b, b ^ (b >> 1));
        end
        conv(1'b0, 4'hF, 4'b1000);
        conv(1'b0, 4'hF, 4'b1000);
        conv(1'b0, 4'b1010, 4'b1111);

        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; bin0 = 4'b0010; bin1 = 4'b1100;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        chk("cont_rst_cnt", conv_cnt, 0);
        for (int n = 0; n < 4; n++) begin
            logic w;
            w = n[0];
            step();
            chk("cont_gnt", {gnt0, gnt1}, w ? 2'b01 : 2'b10);
            step();
            chk("cont_done", {done0, done1}, w ? 2'b01 : 2'b10);
            chk("cont_gray", gray_out, w ? 4'b1010 : 4'b0011);
            step();
            exp_cnt = exp_cnt + 8'd1;
            chk("cont_idle", busy, 0);
            chk("cont_cnt", conv_cnt, exp_cnt);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        req0 = 1'b1; bin0 = 4'b0101;
        step();
        chk("stab_gnt0", gnt0, 1);
        req0 = 1'b0; bin0 = 4'b0000;
        step();
        chk("stab_done0", done0, 1);
        chk("stab_gray", gray_out, 4'b0111);
        step();

        req0 = 1'b1; bin0 = 4'b0011;
        step();
        chk("abort_gnt0", gnt0, 1);
        req0 = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        chk("abort_done", {done0, done1}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_gray", gray_out, 0);
        chk("abort_cnt", conv_cnt, 0);
        step();
        chk("abort_nodone", {done0, done1, busy}, 0);
        conv(1'b0, 4'b0110, 4'b0101);

        for (int i = 0; i < 255; i++) conv(i[0], 4'b1001, 4'b1101);
        chk("wrap_cnt", conv_cnt, 0);

        req0 = 1'b1; bin0 = 4'b0001;
        step();
        chk("late_gnt0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0; req1 = 1'b1; bin1 = 4'b1000;
        step();
        chk("late_done0", {done0, done1, gnt1}, 3'b100);
        chk("late_gray0", gray_out, 4'b0001);
        step();
        chk("late_idle", {busy, gnt0, gnt1, done0, done1}, 0);
        step();
        chk("late_gnt1", {gnt0, gnt1}, 2'b01);
        req1 = 1'b0;
        step();
        chk("late_done1", {done0, done1}, 2'b01);
        chk("late_gray1", gray_out, 4'b1100);
        step();
        chk("late_end", {busy, gnt0, gnt1, done0, done1}, 0);
        chk("late_cnt", conv_cnt, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand and result bit width.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high, with ports clk and rst.
REQ-003 Port list SHALL be:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req0  input  1  requester 0 conversion request, level.
- bin0  input  WIDTH  requester 0 binary operand.
- req1  input  1  requester 1 conversion request, level.
- bin1  input  WIDTH  requester 1 binary operand.
- gnt0  output  1  one-cycle pulse; requester 0 operand captured.
- gnt1  output  1  one-cycle pulse; requester 1 operand captured.
- done0  output  1  one-cycle pulse; gray_out valid for requester 0.
- done1  output  1  one-cycle pulse; gray_out valid for requester 1.
- gray_out  output  WIDTH  registered Gray result, shared.
- busy  output  1  high whenever state is not IDLE.
- conv_cnt  output  8  completed-conversion counter.

Function
REQ-004 The FSM SHALL have exactly three states: IDLE, CONVERT, DONE.
REQ-005 req0 and req1 SHALL be sampled only in IDLE; requests in other states are ignored until the FSM returns to IDLE.
REQ-006 In IDLE with at least one request at edge k:
- the winner's bin SHALL be latched into an operand register;
- gnt of the winner SHALL be high for exactly the cycle after edge k;
- the FSM SHALL move to CONVERT.
REQ-007 In CONVERT at edge k+1:
- gray_out SHALL load op ^ (op >> 1), computed over WIDTH bits with MSB unchanged;
- the FSM SHALL move to DONE.
REQ-008 In DONE:
- the done line of the granted requester SHALL be high for exactly one cycle, the cycle after edge k+1;
- at edge k+2 the FSM SHALL return to IDLE.
REQ-009 Timing SHALL be: latency gnt to done of 1 cycle; one conversion per 3 cycles maximum.
REQ-010 Arbitration SHALL be round-robin:
- when both requests are high in IDLE, grant goes to the requester not served last;
- a single requester is always granted regardless of pointer state.
REQ-011 The last-served pointer SHALL update only when the FSM leaves DONE.
REQ-012 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.
REQ-013 gray_out SHALL hold its value in all states except the CONVERT-to-DONE load edge.
REQ-014 conv_cnt SHALL increment by 1 on each exit from DONE, wrapping 255 to 0.
REQ-015 A requester holding req high after its done SHALL be re-arbitrated normally in IDLE; there is no back-to-back priority.
REQ-016 Changes to bin0/bin1 after gnt SHALL NOT affect the in-flight result.

Reset
REQ-017 With rst high at a clock edge, the following SHALL take effect at that edge, overriding all other activity:
- state = IDLE;
- gnt0 = gnt1 = done0 = done1 = 0;
- busy = 0;
- gray_out = 0;
- conv_cnt = 0;
- pointer selects requester 0 first.
REQ-018 Reset asserted in CONVERT or DONE SHALL abort the conversion with no done pulse, and conv_cnt SHALL stay 0.

Verification
REQ-019 Sweep: req0 only, bin0 = 0..15 sequentially, 4'hF repeated twice -> each done0 carries bin^(bin>>1); 4'b1010 gives 4'b1111, 4'b1111 gives 4'b1000; done0 arrives 1 cycle after gnt0.
REQ-020 Contention: req0 = req1 = 1 held from reset, bin0 = 4'b0010, bin1 = 4'b1100 -> grants alternate gnt0, gnt1, gnt0, ...; results 4'b0011 and 4'b1010 on the matching done.
REQ-021 Operand stability: bin0 changed from 4'b0101 to 4'b0000 the cycle after gnt0 -> done0 with gray_out = 4'b0111.
REQ-022 Reset mid-operation: rst pulsed one cycle while in CONVERT -> no done pulse; next cycle busy = 0, gray_out = 0, conv_cnt = 0; next request serviced normally.
REQ-023 Counter wrap: 256 conversions -> conv_cnt reads 0 after the 256th done, and busy deasserts between requests.
REQ-024 Late request: req1 rises while busy serving req0 -> req1 granted in the first IDLE cycle after done0, with no lost or duplicate pulses.
